// File: rtl/mem_load_pkg.sv
// mem_load_pkg: shared types and default geometry for the host memory load port.
// Holds read FSM states, default DW/AW/DEPTH and the default write-entry layout.
package mem_load_pkg;

  localparam int DW_DEF    = 32;
  localparam int AW_DEF    = 9;
  localparam int DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    ISSUE,
    LATCH,
    RESP
  } rstate_e;

  typedef struct packed {
    logic [AW_DEF-1:0]   addr;
    logic [DW_DEF-1:0]   data;
    logic [DW_DEF/8-1:0] strb;
  } wr_entry_t;

endpackage

// File: rtl/mem_load_fifo.sv
// mem_load_fifo: synchronous write-entry FIFO, async active-low reset.
// Ports: push/din in, pop/dout out (head), full, empty, fill occupancy.
module mem_load_fifo
  import mem_load_pkg::*;
#(
  parameter type T     = wr_entry_t,
  parameter int  DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic                       push,
  input  logic                       pop,
  input  T                           din,
  output T                           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] fill
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  T mem [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign fill    = cnt;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/mem_load_port.sv
// mem_load_port: host write FIFO drained into memory, plus ordered read-back.
// Read-back channel (s_r*, r_*, m_re) is functional only with MEM_LOAD_RDBACK_EN.
module mem_load_port
  import mem_load_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic                       s_wvalid,
  output logic                       s_wready,
  input  logic [AW-1:0]              s_waddr,
  input  logic [DW-1:0]              s_wdata,
  input  logic [DW/8-1:0]            s_wstrb,
  input  logic                       s_rvalid,
  output logic                       s_rready,
  input  logic [AW-1:0]              s_raddr,
  output logic                       r_valid,
  input  logic                       r_ready,
  output logic [DW-1:0]              r_data,
  output logic                       m_we,
  output logic                       m_re,
  output logic [AW-1:0]              m_addr,
  output logic [DW-1:0]              m_wdata,
  output logic [DW/8-1:0]            m_wstrb,
  input  logic [DW-1:0]              m_rdata,
  output logic [$clog2(DEPTH+1)-1:0] fill
);

  localparam int SW = DW/8;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
  } entry_t;

  entry_t        din;
  entry_t        head;
  logic          full;
  logic          empty;
  logic          push;
  logic [AW-1:0] raddr;

  assign din  = '{addr: s_waddr, data: s_wdata, strb: s_wstrb};
  assign push = s_wvalid && s_wready;

  mem_load_fifo #(
    .T     (entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .nreset (nreset),
    .push   (push),
    .pop    (m_we),
    .din    (din),
    .dout   (head),
    .full   (full),
    .empty  (empty),
    .fill   (fill)
  );

`ifdef MEM_LOAD_RDBACK_EN

  rstate_e       rstate;
  rstate_e       rnext;
  logic [DW-1:0] rdata_q;
  logic          rd_acc;

  assign rd_acc = s_rvalid && s_rready;
  assign r_data = rdata_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) rstate <= IDLE;
    else         rstate <= rnext;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      raddr   <= '0;
      rdata_q <= '0;
    end else begin
      if (rd_acc)          raddr   <= s_raddr;
      if (rstate == LATCH) rdata_q <= m_rdata;
    end
  end

  // A push on the accept edge must also drain before the read issues.
  always_comb begin
    rnext = rstate;
    unique case (rstate)
      IDLE:  if (rd_acc) rnext = (!empty || push) ? DRAIN : ISSUE;
      DRAIN: if (empty) rnext = ISSUE;
      ISSUE: rnext = LATCH;
      LATCH: rnext = RESP;
      RESP:  if (r_ready) rnext = IDLE;
      default: rnext = IDLE;
    endcase
  end

  always_comb begin
    s_rready = (rstate == IDLE);
    r_valid  = (rstate == RESP);
    m_re     = (rstate == ISSUE);
    s_wready = !full && (rstate != DRAIN);
    m_we     = !empty && (rstate != ISSUE);
  end

`else

  logic unused_rd;

  assign unused_rd = ^{s_rvalid, s_raddr, r_ready, m_rdata};
  assign raddr     = '0;
  assign s_rready  = 1'b0;
  assign r_valid   = 1'b0;
  assign r_data    = '0;
  assign m_re      = 1'b0;
  assign s_wready  = !full;
  assign m_we      = !empty;

`endif

  always_comb begin
    m_addr  = '0;
    m_wdata = '0;
    m_wstrb = '0;
    unique case (1'b1)
      m_we: begin
        m_addr  = head.addr;
        m_wdata = head.data;
        m_wstrb = head.strb;
      end
      m_re:    m_addr = raddr;
      default: m_addr = '0;
    endcase
  end

endmodule
